// File: rtl/i2c_master_sequencer_pkg.sv
// Shared definitions for the I2C transaction sequencer: mode codes,
// control-register bit positions and FSM state encodings.
package i2c_master_sequencer_pkg;

  localparam logic [1:0] MODE_NONE = 2'b00;
  localparam logic [1:0] MODE_R    = 2'b01;
  localparam logic [1:0] MODE_W    = 2'b10;
  localparam logic [1:0] MODE_WR   = 2'b11;

  localparam int CTRL_ST    = 7;
  localparam int CTRL_ABORT = 8;
  localparam int CTRL_FLUSH = 9;

  typedef enum logic [3:0] {
    IDLE, WAIT_RDY, START, ADDR, WDATA, RSTART, RADDR, RDATA, STOP, ERR
  } state_t;

  // Per-byte handshake inside WDATA: pop the FIFO, present the byte, await ACK
  typedef enum logic [1:0] {W_POP, W_SEND, W_ACK} wphase_t;

  // Address byte as it goes on the wire: 7-bit address followed by R/W bit
  function automatic logic [7:0] addrByte(input logic [6:0] addr, input logic rd);
    return {addr, rd};
  endfunction

endpackage

// File: rtl/i2c_master_sequencer_fifo.sv
// Byte FIFO used for both the TX and RX payload buffers. Writes when full
// are dropped; reads when empty leave dataOut at its last value.
module i2c_master_sequencer_fifo #(
  parameter int FIFO_SIZE_EXP = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       put,
  input  logic [7:0] dataIn,
  input  logic       get,
  output logic [7:0] dataOut,
  input  logic       flush,
  output logic       empty,
  output logic       full
);

  localparam int DEPTH = 1 << FIFO_SIZE_EXP;
  localparam logic [FIFO_SIZE_EXP:0] FULL_LEVEL = {1'b1, {FIFO_SIZE_EXP{1'b0}}};

  logic [7:0]             mem [DEPTH];
  logic [FIFO_SIZE_EXP:0] wrPtr;
  logic [FIFO_SIZE_EXP:0] rdPtr;
  logic [FIFO_SIZE_EXP:0] level;
  logic                   doPut;
  logic                   doGet;

  assign level = wrPtr - rdPtr;
  assign empty = (level == '0);
  assign full  = (level == FULL_LEVEL);
  assign doPut = put & ~full & ~flush;
  assign doGet = get & ~empty & ~flush;

  // Pointer update; flush discards all stored bytes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPut) wrPtr <= wrPtr + 1'b1;
      if (doGet) rdPtr <= rdPtr + 1'b1;
    end
  end

  // Storage and registered read port
  always_ff @(posedge clk) begin
    if (doPut) mem[wrPtr[FIFO_SIZE_EXP-1:0]] <= dataIn;
    if (doGet) dataOut <= mem[rdPtr[FIFO_SIZE_EXP-1:0]];
  end

endmodule

// File: rtl/i2c_master_sequencer.sv
// I2C transaction sequencer: turns one ST write into a complete W, R or
// W-restart-R transaction on the byte-level engine, with TX/RX buffering.
module i2c_master_sequencer
  import i2c_master_sequencer_pkg::*;
#(
  parameter int FIFO_DEPTH_EXP = 3,
  parameter int LEN_W          = 16,
  parameter int START_HOLD     = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             isReady,
  output logic             start,
  output logic             send,
  output logic [7:0]       datasend,
  input  logic             sended,
  input  logic             nack,
  output logic             receive,
  input  logic [7:0]       datareceive,
  input  logic             received,
  input  logic [6:0]       address,
  input  logic             loadAddress,
  input  logic [LEN_W-1:0] lenWrite,
  input  logic [LEN_W-1:0] lenRead,
  input  logic             loadLength,
  input  logic [15:0]      control,
  input  logic             loadControl,
  output logic [15:0]      status,
  input  logic             toPut,
  input  logic [7:0]       dataTo,
  input  logic             fromGet,
  output logic [7:0]       dataFrom,
  output logic             done
);

  localparam int HOLD_W = $clog2(START_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(START_HOLD - 1);
  localparam logic [LEN_W-1:0]  LEN_ONE   = {{(LEN_W-1){1'b0}}, 1'b1};

  state_t            state;
  wphase_t           wPhase;
  logic [1:0]        ctrlMode;
  logic              ctrlSt;
  logic [6:0]        addrReg;
  logic [LEN_W-1:0]  lenWrReg, lenRdReg, wrCnt, rdCnt;
  logic [HOLD_W-1:0] holdCnt;
  logic              sendedQ, receivedQ, sendedRise, receivedRise;
  logic              doneFlag, nackErr, lenErr, busy;
  logic              abortReq, flushIdle;
  logic              txEmpty, txFull, rxEmpty, rxFull, txGet, txFlush, rxPut;
  logic [7:0]        txData;
  logic              unusedCtrlBits;

  assign unusedCtrlBits = ^{control[15:10], control[6:2]};

  assign sendedRise   = sended & ~sendedQ;
  assign receivedRise = received & ~receivedQ;
  assign busy         = (state != IDLE);
  assign abortReq     = loadControl & control[CTRL_ABORT];
  assign flushIdle    = loadControl & control[CTRL_FLUSH] & ~busy;
  assign txGet        = (state == WDATA) && (wPhase == W_POP) && !txEmpty;
  assign txFlush      = abortReq | flushIdle | (state == ERR);
  assign rxPut        = (state == RDATA) & receivedRise;
  assign status       = {8'h00, lenErr, nackErr, doneFlag, busy, rxFull, rxEmpty, txFull, txEmpty};

  i2c_master_sequencer_fifo #(.FIFO_SIZE_EXP(FIFO_DEPTH_EXP)) txFifo (
    .clk(clk), .reset(reset), .put(toPut), .dataIn(dataTo), .get(txGet),
    .dataOut(txData), .flush(txFlush), .empty(txEmpty), .full(txFull)
  );

  i2c_master_sequencer_fifo #(.FIFO_SIZE_EXP(FIFO_DEPTH_EXP)) rxFifo (
    .clk(clk), .reset(reset), .put(rxPut), .dataIn(datareceive), .get(fromGet),
    .dataOut(dataFrom), .flush(flushIdle), .empty(rxEmpty), .full(rxFull)
  );

  // Register file, edge detectors and the transaction FSM with registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;       wPhase <= W_POP;
      ctrlMode <= MODE_NONE; ctrlSt <= 1'b0;
      addrReg <= '0;       lenWrReg <= '0;  lenRdReg <= '0;
      wrCnt <= '0;         rdCnt <= '0;     holdCnt <= '0;
      sendedQ <= 1'b0;     receivedQ <= 1'b0;
      doneFlag <= 1'b0;    nackErr <= 1'b0; lenErr <= 1'b0;
      start <= 1'b0;       send <= 1'b0;    receive <= 1'b0;
      datasend <= '0;      done <= 1'b0;
    end else begin
      sendedQ   <= sended;
      receivedQ <= received;
      send      <= 1'b0;
      done      <= 1'b0;
      if (loadAddress && !busy) addrReg <= address;
      if (loadLength && !busy) begin
        lenWrReg <= lenWrite;
        lenRdReg <= lenRead;
      end
      if (abortReq) begin
        state <= IDLE;  ctrlSt <= 1'b0;
        start <= 1'b0;  send <= 1'b0;  receive <= 1'b0;  datasend <= '0;
        done <= 1'b1;   doneFlag <= 1'b1;
      end else begin
        // ST written while busy is simply not latched
        if (loadControl && !busy) begin
          ctrlMode <= control[1:0];
          ctrlSt   <= control[CTRL_ST];
        end
        case (state)
          IDLE: if (ctrlSt && !loadControl) begin
            state <= WAIT_RDY;  ctrlSt <= 1'b0;
            doneFlag <= 1'b0;   nackErr <= 1'b0;  lenErr <= 1'b0;
            wrCnt <= lenWrReg;  rdCnt <= lenRdReg;
          end
          WAIT_RDY: begin
            if (ctrlMode == MODE_NONE || (ctrlMode != MODE_W && rdCnt == '0)) begin
              lenErr <= 1'b1;  done <= 1'b1;  doneFlag <= 1'b1;  state <= IDLE;
            end else if (isReady) begin
              start <= 1'b1;  holdCnt <= '0;  state <= START;
            end
          end
          START, RSTART: begin
            holdCnt <= holdCnt + 1'b1;
            if (holdCnt == HOLD_LAST) begin
              start    <= 1'b0;
              send     <= 1'b1;
              datasend <= addrByte(addrReg, (state == RSTART) || (ctrlMode == MODE_R));
              state    <= (state == START) ? ADDR : RADDR;
            end
          end
          ADDR: if (sendedRise) begin
            if (nack) state <= ERR;
            else if (ctrlMode == MODE_R) state <= RDATA;
            else if (wrCnt != '0) begin
              state <= WDATA;  wPhase <= W_POP;
            end else if (ctrlMode == MODE_WR) begin
              state <= RSTART;  start <= 1'b1;  holdCnt <= '0;
            end else state <= STOP;
          end
          WDATA: begin
            case (wPhase)
              W_POP:  if (!txEmpty) wPhase <= W_SEND;
              W_SEND: begin
                send <= 1'b1;  datasend <= txData;  wPhase <= W_ACK;
              end
              W_ACK: if (sendedRise) begin
                if (nack) state <= ERR;
                else begin
                  if (wrCnt != '0) wrCnt <= wrCnt - LEN_ONE;
                  wPhase <= W_POP;
                  if (wrCnt == LEN_ONE) begin
                    if (ctrlMode == MODE_WR) begin
                      state <= RSTART;  start <= 1'b1;  holdCnt <= '0;
                    end else state <= STOP;
                  end
                end
              end
              default: wPhase <= W_POP;
            endcase
          end
          RADDR: if (sendedRise) state <= nack ? ERR : RDATA;
          RDATA: begin
            // receive falls with each arriving byte and is re-evaluated once the
            // FIFO level and remaining count reflect it; the last byte leaves it low
            if (receivedRise) begin
              receive <= 1'b0;
              if (rdCnt != '0) rdCnt <= rdCnt - LEN_ONE;
              if (rdCnt == LEN_ONE) state <= STOP;
            end else receive <= (rdCnt != '0) && !rxFull;
          end
          STOP: begin
            start <= 1'b0;  send <= 1'b0;  receive <= 1'b0;
            done <= 1'b1;   doneFlag <= 1'b1;  state <= IDLE;
          end
          ERR: begin
            start <= 1'b0;  send <= 1'b0;  receive <= 1'b0;
            nackErr <= 1'b1;  done <= 1'b1;  doneFlag <= 1'b1;  state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_master_sequencer.sv
// Bench for i2c_master_sequencer: engine models answer send/receive, a
// scoreboard checks every byte presented on datasend and every RX read.
module tb_i2c_master_sequencer;

  localparam int LEN_W      = 16;
  localparam int START_HOLD = 15;

  logic             clk = 1'b0;
  logic             reset;
  logic             isReady;
  logic             start, send, receive, done;
  logic [7:0]       datasend, datareceive, dataTo, dataFrom;
  logic             sended, nack, received;
  logic [6:0]       address;
  logic             loadAddress, loadLength, loadControl, toPut, fromGet;
  logic [LEN_W-1:0] lenWrite, lenRead;
  logic [15:0]      control, status;

  int checks = 0;
  int errors = 0;
  int doneCount = 0;
  int startRun = 0;
  bit startSeen = 0;
  bit getPend = 0;

  logic [7:0] expSend[$];
  logic [7:0] rxExp[$];
  logic [7:0] rxBytes[$];
  logic       nackQ[$];

  i2c_master_sequencer #(.FIFO_DEPTH_EXP(1), .LEN_W(LEN_W), .START_HOLD(START_HOLD)) dut (
    .clk(clk), .reset(reset), .isReady(isReady), .start(start), .send(send),
    .datasend(datasend), .sended(sended), .nack(nack), .receive(receive),
    .datareceive(datareceive), .received(received), .address(address),
    .loadAddress(loadAddress), .lenWrite(lenWrite), .lenRead(lenRead),
    .loadLength(loadLength), .control(control), .loadControl(loadControl),
    .status(status), .toPut(toPut), .dataTo(dataTo), .fromGet(fromGet),
    .dataFrom(dataFrom), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic putTx(input logic [7:0] b);
    toPut = 1'b1; dataTo = b;
    tick();
    toPut = 1'b0;
  endtask

  task automatic popRx(input logic [7:0] b);
    rxExp.push_back(b);
    fromGet = 1'b1;
    tick();
    fromGet = 1'b0;
    tick();
  endtask

  task automatic setup(input logic [6:0] a, input int lw, input int lr);
    address = a; lenWrite = LEN_W'(lw); lenRead = LEN_W'(lr);
    loadAddress = 1'b1; loadLength = 1'b1;
    tick();
    loadAddress = 1'b0; loadLength = 1'b0;
  endtask

  task automatic ctrlWrite(input logic [15:0] v);
    control = v; loadControl = 1'b1;
    tick();
    loadControl = 1'b0; control = '0;
  endtask

  task automatic waitDone(input string name, input int maxCyc);
    int base;
    base = doneCount;
    for (int i = 0; i < maxCyc && doneCount == base; i++) @(negedge clk);
    check(name, 32'(doneCount > base), 1);
  endtask

  // Scoreboard monitor: bytes on datasend, start hold length, done pulses, RX reads
  always @(negedge clk) begin
    if (send) begin
      if (expSend.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpectedSend: actual %0h required none", datasend);
      end else check("datasend", datasend, expSend.pop_front());
    end
    if (start) begin
      startRun++; startSeen = 1;
    end else if (startRun > 0) begin
      check("startHold", startRun, START_HOLD);
      startRun = 0;
    end
    if (done) doneCount++;
    if (getPend) begin
      if (rxExp.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpectedRead: actual %0h required none", dataFrom);
      end else check("dataFrom", dataFrom, rxExp.pop_front());
    end
    getPend = fromGet && !status[2];
  end

  // Engine model, transmit side: acknowledge each send after a short delay
  initial begin
    sended = 0; nack = 0;
    forever begin
      @(negedge clk);
      if (send) begin
        repeat (3) @(negedge clk);
        nack = (nackQ.size() > 0) ? nackQ.pop_front() : 1'b0;
        sended = 1;
        repeat (2) @(negedge clk);
        sended = 0; nack = 0;
      end
    end
  end

  // Engine model, receive side: deliver queued bytes while receive is high
  initial begin
    received = 0; datareceive = 0;
    forever begin
      @(negedge clk);
      if (receive && rxBytes.size() > 0) begin
        repeat (3) @(negedge clk);
        datareceive = rxBytes.pop_front();
        received = 1;
        repeat (2) @(negedge clk);
        received = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout required finish");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    reset = 0; isReady = 1; address = 0; loadAddress = 0; lenWrite = 0; lenRead = 0;
    loadLength = 0; control = 0; loadControl = 0; toPut = 0; dataTo = 0; fromGet = 0;
    repeat (3) @(negedge clk);
    check("rstOutputs", {start, send, receive, done, datasend}, 0);
    check("rstStatus", status, 16'h0005);
    @(posedge clk); #1 reset = 1;
    tick();

    // FLUSH in IDLE empties the TX FIFO
    putTx(8'h5A);
    check("txNotEmpty", status[0], 0);
    ctrlWrite(16'h0200);
    check("flushTx", status[0], 1);

    // W to 0x77, two bytes; a third put while full is dropped
    setup(7'h77, 2, 0);
    putTx(8'hF4); putTx(8'h2E); putTx(8'h99);
    check("txFull", status[1], 1);
    expSend.push_back(8'hEE); expSend.push_back(8'hF4); expSend.push_back(8'h2E);
    ctrlWrite(16'h0082);
    waitDone("wDone", 400);
    check("wStatus65", status[6:5], 2'b01);
    check("wTxEmpty", status[0], 1);
    check("wAllSent", expSend.size(), 0);
    repeat (5) tick();

    // WR: write 0xD0, restart, read one byte 0x55
    setup(7'h77, 1, 1);
    putTx(8'hD0);
    rxBytes.push_back(8'h55);
    expSend.push_back(8'hEE); expSend.push_back(8'hD0); expSend.push_back(8'hEF);
    ctrlWrite(16'h0083);
    waitDone("wrDone", 600);
    check("wrRecvLow", receive, 0);
    check("wrAllSent", expSend.size(), 0);
    popRx(8'h55);
    fromGet = 1; tick(); fromGet = 0; tick();
    check("rxEmptyHold", dataFrom, 8'h55);
    repeat (5) tick();

    // R of three bytes with reads held off until the RX FIFO fills
    setup(7'h77, 0, 3);
    rxBytes.push_back(8'hA1); rxBytes.push_back(8'hA2); rxBytes.push_back(8'hA3);
    expSend.push_back(8'hEF);
    ctrlWrite(16'h0081);
    for (int i = 0; i < 400 && !status[3]; i++) tick();
    check("rxFullReached", status[3], 1);
    repeat (10) tick();
    check("rxStallRecv", receive, 0);
    check("rxStallPending", rxBytes.size(), 1);
    popRx(8'hA1); popRx(8'hA2);
    waitDone("rDone", 400);
    popRx(8'hA3);
    check("rRxEmpty", status[2], 1);
    repeat (5) tick();

    // W with address NACK: no payload, nackErr, TX flushed
    setup(7'h77, 2, 0);
    putTx(8'h11); putTx(8'h22);
    nackQ.push_back(1'b1);
    expSend.push_back(8'hEE);
    ctrlWrite(16'h0082);
    waitDone("nackDone", 400);
    check("nackErr", status[6:5], 2'b11);
    check("nackTxEmpty", status[0], 1);
    repeat (10) tick();
    check("nackNoPayload", expSend.size(), 0);

    // R with lenRead=0: length error without START
    setup(7'h77, 0, 0);
    startSeen = 0;
    ctrlWrite(16'h0081);
    waitDone("lenDone", 4);
    check("lenErr", status[7], 1);
    check("lenNoStart", startSeen, 0);
    repeat (5) tick();

    // ABORT while a payload byte is awaiting its ACK, second byte still queued
    setup(7'h77, 2, 0);
    putTx(8'h33); putTx(8'h44);
    expSend.push_back(8'hEE); expSend.push_back(8'h33); expSend.push_back(8'h44);
    ctrlWrite(16'h0082);
    for (int i = 0; i < 400 && expSend.size() > 1; i++) tick();
    check("abortReached", expSend.size(), 1);
    ctrlWrite(16'h0100);
    waitDone("abortDone", 4);
    check("abortIdle", {status[4], start, send, receive}, 0);
    check("abortTxFlushed", status[0], 1);
    expSend.delete();
    repeat (10) tick();

    // Asynchronous reset in the middle of a read: silent, outputs cleared
    setup(7'h77, 0, 2);
    rxBytes.push_back(8'hB1); rxBytes.push_back(8'hB2);
    expSend.push_back(8'hEF);
    ctrlWrite(16'h0081);
    for (int i = 0; i < 400 && status[2]; i++) @(negedge clk);
    check("rstMidRead", status[2], 0);
    base = doneCount;
    #2 reset = 0;
    #1;
    check("rstMidOutputs", {start, send, receive, datasend}, 0);
    check("rstMidStatus", status, 16'h0005);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 reset = 1;
    repeat (20) tick();
    check("rstNoDone", doneCount - base, 0);
    rxBytes.delete();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
